// File: rtl/mem_access_stage.sv
// mem_access_stage: MEM pipeline stage plus the MEM/WB boundary register.
// Issues one request per load/store to a multi-cycle data memory, stalls the
// upstream pipeline until the memory answers (or a watchdog expires), then hands
// the writeback bundle to WB. WB receives bubbles while the stage is stalled.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   i_mem_read / i_mem_write   load / store in MEM (both set is treated as a store)
//   i_mem_to_reg, i_reg_write  WB controls from EX/MEM
//   i_halt                     halt marker from EX/MEM
//   i_alu_val                  byte address for ld/st, otherwise ALU result
//   i_read_data2               store data
//   i_dst_reg                  destination register
//   i_mem_rdata, i_mem_valid   memory completion (read data or write ack)
//   o_mem_req, o_mem_wr        one-cycle request pulse, write qualifier
//   o_mem_addr, o_mem_wdata    word-aligned address and store data
//   o_mem_stall                freeze PC, IF/ID, ID/EX, EX/MEM
//   o_mem_err                  sticky watchdog timeout flag
//   o_wb_*                     registered writeback bundle
module mem_access_stage #(
    parameter int unsigned TIMEOUT_CYC = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_mem_read,
    input  logic        i_mem_write,
    input  logic        i_mem_to_reg,
    input  logic        i_reg_write,
    input  logic        i_halt,
    input  logic [15:0] i_alu_val,
    input  logic [15:0] i_read_data2,
    input  logic [3:0]  i_dst_reg,
    input  logic [15:0] i_mem_rdata,
    input  logic        i_mem_valid,
    output logic        o_mem_req,
    output logic        o_mem_wr,
    output logic [15:0] o_mem_addr,
    output logic [15:0] o_mem_wdata,
    output logic        o_mem_stall,
    output logic        o_mem_err,
    output logic        o_wb_mem_to_reg,
    output logic        o_wb_reg_write,
    output logic        o_wb_halt,
    output logic [15:0] o_wb_alu_val,
    output logic [15:0] o_wb_mem_data,
    output logic [3:0]  o_wb_dst_reg
);

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    localparam logic [7:0] CntLast = 8'(TIMEOUT_CYC - 1);

    state_e      r_state, w_state_next;
    logic [7:0]  r_cnt, w_cnt_next;
    logic [15:0] r_hold, w_hold_next;
    logic        r_err, w_err_next;
    logic        w_acc;

    logic        r_wb_mem_to_reg, r_wb_reg_write, r_wb_halt;
    logic [15:0] r_wb_alu_val, r_wb_mem_data;
    logic [3:0]  r_wb_dst_reg;

    assign w_acc = i_mem_read | i_mem_write;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
            r_cnt   <= 8'd0;
            r_hold  <= 16'd0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_hold  <= w_hold_next;
            r_err   <= w_err_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_hold_next  = r_hold;
        w_err_next   = r_err;
        unique case (r_state)
            StIdle: begin
                if (w_acc) begin
                    w_state_next = StBusy;
                    w_cnt_next   = 8'd0;
                end
            end
            StBusy: begin
                w_cnt_next = r_cnt + 8'd1;
                // A completion in the final watchdog cycle still wins over the timeout.
                if (i_mem_valid) begin
                    w_hold_next  = i_mem_rdata;
                    w_state_next = StDone;
                end else if (r_cnt == CntLast) begin
                    w_err_next   = 1'b1;
                    w_hold_next  = 16'd0;
                    w_state_next = StDone;
                end
            end
            StDone: begin
                // Upstream advances during DONE, so IDLE sees a fresh instruction.
                w_state_next = StIdle;
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    // Output logic
    always_comb begin
        o_mem_req   = 1'b0;
        o_mem_stall = 1'b0;
        unique case (r_state)
            StIdle: begin
                o_mem_req   = w_acc;
                o_mem_stall = w_acc;
            end
            StBusy: begin
                o_mem_stall = 1'b1;
            end
            StDone: begin
                o_mem_stall = 1'b0;
            end
            default: begin
                o_mem_stall = 1'b0;
            end
        endcase
    end

    assign o_mem_wr    = o_mem_req & i_mem_write;
    assign o_mem_addr  = {i_alu_val[15:1], 1'b0};
    assign o_mem_wdata = i_read_data2;
    assign o_mem_err   = r_err;

    // MEM/WB register: control fields are squashed to a bubble while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wb_mem_to_reg <= 1'b0;
            r_wb_reg_write  <= 1'b0;
            r_wb_halt       <= 1'b0;
            r_wb_alu_val    <= 16'd0;
            r_wb_mem_data   <= 16'd0;
            r_wb_dst_reg    <= 4'd0;
        end else begin
            r_wb_alu_val  <= i_alu_val;
            r_wb_dst_reg  <= i_dst_reg;
            r_wb_mem_data <= (r_state == StDone) ? r_hold : i_mem_rdata;
            if (o_mem_stall) begin
                r_wb_mem_to_reg <= 1'b0;
                r_wb_reg_write  <= 1'b0;
                r_wb_halt       <= 1'b0;
            end else begin
                r_wb_mem_to_reg <= i_mem_to_reg;
                r_wb_reg_write  <= i_reg_write;
                r_wb_halt       <= i_halt;
            end
        end
    end

    assign o_wb_mem_to_reg = r_wb_mem_to_reg;
    assign o_wb_reg_write  = r_wb_reg_write;
    assign o_wb_halt       = r_wb_halt;
    assign o_wb_alu_val    = r_wb_alu_val;
    assign o_wb_mem_data   = r_wb_mem_data;
    assign o_wb_dst_reg    = r_wb_dst_reg;

endmodule

// File: tb/tb_mem_access_stage.sv
// Testbench for mem_access_stage: directed scenarios followed by randomized
// instruction streams, each checked against a transaction-level expectation.
module tb_mem_access_stage;

    localparam int TimeoutCyc = 15;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_mem_read, i_mem_write, i_mem_to_reg, i_reg_write, i_halt;
    logic [15:0] i_alu_val, i_read_data2, i_mem_rdata;
    logic [3:0]  i_dst_reg;
    logic        i_mem_valid;
    logic        o_mem_req, o_mem_wr, o_mem_stall, o_mem_err;
    logic [15:0] o_mem_addr, o_mem_wdata;
    logic        o_wb_mem_to_reg, o_wb_reg_write, o_wb_halt;
    logic [15:0] o_wb_alu_val, o_wb_mem_data;
    logic [3:0]  o_wb_dst_reg;

    int   n_checks = 0;
    int   n_fail   = 0;
    logic exp_err  = 1'b0;

    always #5 clk = ~clk;

    mem_access_stage #(.TIMEOUT_CYC(TimeoutCyc)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .i_mem_read      (i_mem_read),
        .i_mem_write     (i_mem_write),
        .i_mem_to_reg    (i_mem_to_reg),
        .i_reg_write     (i_reg_write),
        .i_halt          (i_halt),
        .i_alu_val       (i_alu_val),
        .i_read_data2    (i_read_data2),
        .i_dst_reg       (i_dst_reg),
        .i_mem_rdata     (i_mem_rdata),
        .i_mem_valid     (i_mem_valid),
        .o_mem_req       (o_mem_req),
        .o_mem_wr        (o_mem_wr),
        .o_mem_addr      (o_mem_addr),
        .o_mem_wdata     (o_mem_wdata),
        .o_mem_stall     (o_mem_stall),
        .o_mem_err       (o_mem_err),
        .o_wb_mem_to_reg (o_wb_mem_to_reg),
        .o_wb_reg_write  (o_wb_reg_write),
        .o_wb_halt       (o_wb_halt),
        .o_wb_alu_val    (o_wb_alu_val),
        .o_wb_mem_data   (o_wb_mem_data),
        .o_wb_dst_reg    (o_wb_dst_reg)
    );

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%04h expected 0x%04h", tag, got, exp);
        end
    endtask

    task automatic clear_inputs();
        i_mem_read   = 1'b0;
        i_mem_write  = 1'b0;
        i_mem_to_reg = 1'b0;
        i_reg_write  = 1'b0;
        i_halt       = 1'b0;
        i_alu_val    = 16'd0;
        i_read_data2 = 16'd0;
        i_dst_reg    = 4'd0;
        i_mem_rdata  = 16'd0;
        i_mem_valid  = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_req"},    16'(o_mem_req), 16'd0);
        check_eq({tag, "_wr"},     16'(o_mem_wr), 16'd0);
        check_eq({tag, "_stall"},  16'(o_mem_stall), 16'd0);
        check_eq({tag, "_err"},    16'(o_mem_err), 16'd0);
        check_eq({tag, "_addr"},   o_mem_addr, 16'd0);
        check_eq({tag, "_wdata"},  o_mem_wdata, 16'd0);
        check_eq({tag, "_wb_rw"},  16'(o_wb_reg_write), 16'd0);
        check_eq({tag, "_wb_m2r"}, 16'(o_wb_mem_to_reg), 16'd0);
        check_eq({tag, "_wb_hlt"}, 16'(o_wb_halt), 16'd0);
        check_eq({tag, "_wb_alu"}, o_wb_alu_val, 16'd0);
        check_eq({tag, "_wb_md"},  o_wb_mem_data, 16'd0);
        check_eq({tag, "_wb_dst"}, 16'(o_wb_dst_reg), 16'd0);
    endtask

    // Presents one instruction in MEM starting at posedge+1 and returns at
    // posedge+1 of the cycle after it reaches WB. lat = cycles from request to
    // mem_valid (0 = memory never answers).
    task automatic run_instr(input logic rd, input logic wr, input logic m2r, input logic rw,
                             input logic hlt, input logic [15:0] alu, input logic [15:0] wd,
                             input logic [3:0] dst, input int lat, input logic [15:0] rdata);
        logic        acc, stray, released;
        logic [15:0] pass_rdata, exp_md;
        int          b, stalls, reqs, n;
        i_mem_read   = rd;
        i_mem_write  = wr;
        i_mem_to_reg = m2r;
        i_reg_write  = rw;
        i_halt       = hlt;
        i_alu_val    = alu;
        i_read_data2 = wd;
        i_dst_reg    = dst;
        i_mem_valid  = 1'b0;
        pass_rdata   = 16'($urandom);
        i_mem_rdata  = pass_rdata;
        stray        = 1'($urandom_range(0, 1));
        #1;
        acc = rd | wr;
        check_eq("req_issue", 16'(o_mem_req), 16'(acc));
        check_eq("stall_issue", 16'(o_mem_stall), 16'(acc));
        exp_md = pass_rdata;
        if (acc) begin
            check_eq("wr_issue", 16'(o_mem_wr), 16'(wr));
            check_eq("addr", o_mem_addr, {alu[15:1], 1'b0});
            check_eq("wdata", o_mem_wdata, wd);
            b        = (lat == 0) ? TimeoutCyc : lat;
            stalls   = 1;
            reqs     = 1;
            n        = 0;
            released = 1'b0;
            while (!released && n < 40) begin
                @(posedge clk);
                #1;
                check_eq("bubble_rw", 16'(o_wb_reg_write), 16'd0);
                check_eq("bubble_m2r", 16'(o_wb_mem_to_reg), 16'd0);
                check_eq("bubble_halt", 16'(o_wb_halt), 16'd0);
                n++;
                // Stray valid in the release cycle must be ignored.
                i_mem_valid = (n == lat) || (n == b + 1 && stray);
                i_mem_rdata = (n == lat) ? rdata : 16'($urandom);
                #1;
                if (o_mem_req) reqs++;
                if (o_mem_stall) stalls++;
                else released = 1'b1;
            end
            check_eq("released", 16'(released), 16'd1);
            check_eq("stall_cycles", 16'(stalls), 16'(1 + b));
            check_eq("req_count", 16'(reqs), 16'd1);
            if (lat == 0) exp_err = 1'b1;
            exp_md = (lat == 0) ? 16'd0 : rdata;
        end
        @(posedge clk);
        #1;
        i_mem_valid = 1'b0;
        check_eq("wb_rw", 16'(o_wb_reg_write), 16'(rw));
        check_eq("wb_m2r", 16'(o_wb_mem_to_reg), 16'(m2r));
        check_eq("wb_halt", 16'(o_wb_halt), 16'(hlt));
        check_eq("wb_alu", o_wb_alu_val, alu);
        check_eq("wb_dst", 16'(o_wb_dst_reg), 16'(dst));
        check_eq("wb_memdata", o_wb_mem_data, exp_md);
        check_eq("err", 16'(o_mem_err), 16'(exp_err));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "testbench timeout");
    end

    initial begin
        rst_n = 1'b0;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // ALU op passes through in one cycle
        run_instr(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h1234, 16'h0000, 4'd5, 0, 16'h0000);
        // Load, misaligned address, answer after 4 cycles
        run_instr(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0041, 16'h0000, 4'd3, 4, 16'hBEEF);
        // Store, ack after 2 cycles
        run_instr(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0010, 16'hA5A5, 4'd0, 2, 16'h0000);
        // Back-to-back loads
        run_instr(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0002, 16'h0000, 4'd1, 1, 16'h1111);
        run_instr(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0004, 16'h0000, 4'd2, 3, 16'h2222);
        // Answer in the last watchdog cycle still counts as a completion
        run_instr(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0006, 16'h0000, 4'd4, TimeoutCyc, 16'h3333);
        // Memory never answers
        run_instr(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0008, 16'h0000, 4'd6, 0, 16'h0000);
        // Pipeline continues after an error; halt forwarded when not stalled
        run_instr(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h00FF, 16'h0000, 4'd0, 0, 16'h0000);

        // Reset during BUSY, then a late mem_valid
        i_mem_read  = 1'b1;
        i_reg_write = 1'b1;
        i_alu_val   = 16'h0020;
        #1;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        check_eq("pre_reset_stall", 16'(o_mem_stall), 16'd1);
        rst_n = 1'b0;
        clear_inputs();
        #1;
        check_all_zero("midreset");
        exp_err = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        i_mem_valid = 1'b1;
        #1;
        check_eq("late_valid_stall", 16'(o_mem_stall), 16'd0);
        check_eq("late_valid_req", 16'(o_mem_req), 16'd0);
        @(posedge clk);
        #1;
        i_mem_valid = 1'b0;
        check_all_zero("post_reset");
        run_instr(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0031, 16'h0000, 4'd7, 3, 16'hC0DE);

        // Randomized instruction stream
        for (int i = 0; i < 150; i++) begin
            int   kind, lat;
            logic rd, wr;
            kind = int'($urandom_range(0, 3));
            rd   = (kind == 1) || (kind == 3);
            wr   = (kind == 2) || (kind == 3);
            lat  = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, TimeoutCyc));
            run_instr(rd, wr, 1'($urandom), 1'($urandom), 1'($urandom), 16'($urandom),
                      16'($urandom), 4'($urandom), lat, 16'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
